// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, default reset vector and
// the {pc, instr} record held in the instruction queue.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Small circular FIFO of fetched {pc, instr} entries. Flush wins over push and pop;
// the head is read straight from registered storage.
module ifetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned QDEPTH = 2,
   localparam int unsigned PtrW = $clog2(QDEPTH),
   localparam int unsigned CntW = $clog2(QDEPTH + 1)
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            push_i,
   input  logic [XLEN-1:0] wpc_i,
   input  logic [ILEN-1:0] winstr_i,
   input  logic            pop_i,
   output logic [XLEN-1:0] rpc_o,
   output logic [ILEN-1:0] rinstr_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   if (QDEPTH != 2 && QDEPTH != 4) begin : g_bad_depth
      $error("ifetch_queue: QDEPTH must be 2 or 4");
   end

   localparam logic [PtrW-1:0] PtrLast = PtrW'(QDEPTH - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(QDEPTH);

   fetch_entry_t    mem_q [QDEPTH];
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_en, pop_en;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   assign full_o   = (count_q == CntFull);
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign rpc_o    = mem_q[rptr_q].pc;
   assign rinstr_o = mem_q[rptr_q].instr;

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign pop_en  = pop_i && !empty_o && !flush_i;
   assign push_en = push_i && (!full_o || pop_en) && !flush_i;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (pop_en) rptr_d = ptr_inc(rptr_q);
         if (push_en) wptr_d = ptr_inc(wptr_q);
         count_d = count_q + CntW'(push_en) - CntW'(pop_en);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en && !reset_i) begin
         mem_q[wptr_q] <= '{pc: wpc_i, instr: winstr_i};
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the pc, issues one fetch per cycle into the
// queue, and restarts from a redirect target when a taken branch arrives.
module ifetch
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned     QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] iaddr,
   input  logic [ILEN-1:0] idata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            instr_valid,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready
);

   localparam int unsigned CntW = $clog2(QDEPTH + 1);

   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("ifetch: RESET_PC must be word aligned");
   end

   logic [XLEN-1:0] pc_q, pc_d;
   logic            q_full, q_empty;
   logic [CntW-1:0] q_count;
   logic            pop, can_accept, fetch;

   assign iaddr       = pc_q;
   assign instr_valid = !q_empty;
   assign pop         = instr_valid && instr_ready;
   assign can_accept  = !q_full || pop;
   assign fetch       = can_accept && !halt && !redirect_valid;

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (fetch) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   ifetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk_i    (clk),
      .reset_i  (reset),
      .flush_i  (redirect_valid),
      .push_i   (fetch),
      .wpc_i    (pc_q),
      .winstr_i (idata),
      .pop_i    (pop),
      .rpc_o    (instr_pc),
      .rinstr_o (instr),
      .full_o   (q_full),
      .empty_o  (q_empty),
      .count_o  (q_count)
   );

   a_count_bound: assert property (@(posedge clk) disable iff (reset)
      (q_count <= CntW'(QDEPTH)) && (q_full == (q_count == CntW'(QDEPTH))));

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a vector table of per-cycle inputs and expected
// outputs, followed by a backpressure run checked against a simple pc scoreboard.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   ifetch #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .iaddr          (iaddr),
      .idata          (idata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   // Memory word k (byte address 4k) holds 0x1000_0000 + k.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   assign idata = mem_word(iaddr);

   typedef struct {
      logic        chk;
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        hlt;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eia;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic chk, input logic rst, input logic rv,
                               input logic [31:0] rpc, input logic hlt, input logic rdy,
                               input logic ev, input logic [31:0] epc,
                               input logic [31:0] eia);
      vec_t v;
      v.chk = chk; v.rst = rst; v.rv = rv; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
      v.ev = ev; v.epc = epc; v.eia = eia;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   int   exp_pc;
   int   consumed;

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      instr_ready    = 1'b0;

      // Reset release and full-rate streaming
      vecs.push_back(mk(0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h0, 32'h4));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h4, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h8, 32'hC));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'hC, 32'h10));
      // Fill with decode stalled, then release
      vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 1, 32'h10, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h4));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h0, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h4, 32'hC));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h8, 32'h10));
      // Redirect to unaligned 0x42 with two entries queued
      vecs.push_back(mk(1, 0, 1, 32'h42, 0, 0, 1, 32'hC, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h40));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h40, 32'h44));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h44, 32'h48));
      // Full queue, pop and redirect together
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h48, 32'h4C));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h48, 32'h50));
      vecs.push_back(mk(1, 0, 1, 32'h100, 0, 1, 1, 32'h48, 32'h50));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h100));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h100, 32'h104));
      // Halt drains the queue, then redirect during halt
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h104, 32'h108));
      vecs.push_back(mk(1, 0, 0, 32'h0, 1, 1, 1, 32'h104, 32'h10C));
      vecs.push_back(mk(1, 0, 0, 32'h0, 1, 1, 1, 32'h108, 32'h10C));
      vecs.push_back(mk(1, 0, 0, 32'h0, 1, 1, 0, 32'h0, 32'h10C));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h10C));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h10C, 32'h110));
      vecs.push_back(mk(1, 0, 1, 32'h203, 1, 1, 1, 32'h110, 32'h114));
      vecs.push_back(mk(1, 0, 0, 32'h0, 1, 1, 0, 32'h0, 32'h200));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h200));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h200, 32'h204));
      // pc wrap, then reset mid-stream overriding redirect and halt
      vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFF8, 0, 1, 1, 32'h204, 32'h208));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'hFFFF_FFF8));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0));
      vecs.push_back(mk(1, 1, 1, 32'h300, 1, 1, 1, 32'h0, 32'h4));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 1, 32'h0, 32'h4));

      foreach (vecs[i]) begin
         @(negedge clk);
         reset          = vecs[i].rst;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         halt           = vecs[i].hlt;
         instr_ready    = vecs[i].rdy;
         #1;
         if (vecs[i].chk) begin
            check32($sformatf("row%0d iaddr", i), iaddr, vecs[i].eia);
            check32($sformatf("row%0d instr_valid", i), {31'b0, instr_valid},
                    {31'b0, vecs[i].ev});
            if (vecs[i].ev) begin
               check32($sformatf("row%0d instr_pc", i), instr_pc, vecs[i].epc);
               check32($sformatf("row%0d instr", i), instr, mem_word(vecs[i].epc));
            end
         end
      end

      // Backpressure pattern ready = 1,1,0,...: no bubbles, no loss, no duplicates
      @(negedge clk);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      halt           = 1'b0;
      instr_ready    = 1'b0;
      exp_pc   = 0;
      consumed = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         reset       = 1'b0;
         instr_ready = (i % 3 != 2);
         #1;
         if (i == 0) begin
            check32("bp first valid", {31'b0, instr_valid}, 32'd0);
            check32("bp first iaddr", iaddr, 32'h0);
         end else begin
            check32($sformatf("bp%0d no bubble", i), {31'b0, instr_valid}, 32'd1);
         end
         if (instr_valid) begin
            check32($sformatf("bp%0d instr_pc", i), instr_pc, exp_pc);
            check32($sformatf("bp%0d instr", i), instr, mem_word(exp_pc));
            if (instr_ready) begin
               exp_pc += 4;
               consumed++;
            end
         end
      end
      check32("bp consumed", consumed, 32'd19);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
